// File: rtl/id_stage_hz_if.sv
// Bus bundle between IF/EX/MEM/WB and the ID stage, plus the ID stage outputs.
// The master side drives the pipeline inputs; the slave side is the ID stage.
interface id_stage_hz_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  if_valid;
   logic [31:0]           if_inst;
   logic [DATA_W-1:0]     if_pc4;
   logic                  flush;
   logic                  ex_m2reg;
   logic                  ex_wreg;
   logic [REG_ADDR_W-1:0] ex_destR;
   logic                  mem_wreg;
   logic [REG_ADDR_W-1:0] mem_destR;
   logic [DATA_W-1:0]     mem_result;
   logic                  wb_wreg;
   logic [REG_ADDR_W-1:0] wb_destR;
   logic [DATA_W-1:0]     wb_dest;
   logic [REG_ADDR_W-1:0] which_reg;

   logic [DATA_W-1:0]     reg_content;
   logic                  id_ready;
   logic                  id_valid;
   logic [31:0]           id_inst;
   logic [DATA_W-1:0]     id_pc4;
   logic [DATA_W-1:0]     id_inA;
   logic [DATA_W-1:0]     id_inB;
   logic [DATA_W-1:0]     id_imm;
   logic [REG_ADDR_W-1:0] rs;
   logic [REG_ADDR_W-1:0] rt;
   logic [REG_ADDR_W-1:0] rd;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output if_valid, if_inst, if_pc4, flush, ex_m2reg, ex_wreg, ex_destR,
             mem_wreg, mem_destR, mem_result, wb_wreg, wb_destR, wb_dest, which_reg,
      input  reg_content, id_ready, id_valid, id_inst, id_pc4, id_inA, id_inB,
             id_imm, rs, rt, rd, stall_cnt
   );

   modport slave (
      input  if_valid, if_inst, if_pc4, flush, ex_m2reg, ex_wreg, ex_destR,
             mem_wreg, mem_destR, mem_result, wb_wreg, wb_destR, wb_dest, which_reg,
      output reg_content, id_ready, id_valid, id_inst, id_pc4, id_inA, id_inB,
             id_imm, rs, rt, rd, stall_cnt
   );
endinterface

// File: rtl/id_stage_hz.sv
// MIPS ID stage: IF/ID register, register file with WB write-through,
// load-use stall detection, MEM/WB operand forwarding and a stall counter.
module id_stage_hz #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input logic          clk,
   input logic          rst,
   id_stage_hz_if.slave bus
);
   localparam int NUM_REGS = 2**REG_ADDR_W;

   logic                  r_valid;
   logic [31:0]           r_inst;
   logic [DATA_W-1:0]     r_pc4;
   logic [DATA_W-1:0]     r_regs [NUM_REGS];
   logic [CNT_W-1:0]      r_stall_cnt;

   logic [5:0]            w_opcode;
   logic [REG_ADDR_W-1:0] w_rs;
   logic [REG_ADDR_W-1:0] w_rt;
   logic [REG_ADDR_W-1:0] w_rd;
   logic                  w_uses_rt;
   logic                  w_zext;
   logic                  w_stall;
   logic [REG_ADDR_W-1:0] w_addr [2];
   logic [DATA_W-1:0]     w_rf   [2];
   logic [DATA_W-1:0]     w_op   [2];

   assign w_opcode  = r_inst[31:26];
   assign w_rs      = REG_ADDR_W'(r_inst[25:21]);
   assign w_rt      = REG_ADDR_W'(r_inst[20:16]);
   assign w_rd      = REG_ADDR_W'(r_inst[15:11]);
   assign w_uses_rt = w_opcode inside {6'h00, 6'h04, 6'h05, 6'h2B};
   assign w_zext    = w_opcode inside {6'h0C, 6'h0D, 6'h0E};

   // Only the load's result is late; ALU results are covered by forwarding.
   assign w_stall = r_valid & bus.ex_m2reg & bus.ex_wreg & (bus.ex_destR != '0) &
                    ((bus.ex_destR == w_rs) | (w_uses_rt & (bus.ex_destR == w_rt)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_inst  <= '0;
         r_pc4   <= '0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
         r_inst  <= '0;
      end else if (!w_stall) begin
         r_valid <= bus.if_valid;
         r_inst  <= bus.if_inst;
         r_pc4   <= bus.if_pc4;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (bus.wb_wreg && (bus.wb_destR != '0)) begin
         r_regs[bus.wb_destR] <= bus.wb_dest;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign w_addr[0] = w_rs;
   assign w_addr[1] = w_rt;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
         // Register read with same-cycle WB write-through; r0 is hard zero.
         assign w_rf[gi] = (w_addr[gi] == '0) ? '0 :
                           (bus.wb_wreg && (bus.wb_destR == w_addr[gi])) ? bus.wb_dest :
                           r_regs[w_addr[gi]];
         if (FWD_EN != 0) begin : g_fwd
            assign w_op[gi] = (w_addr[gi] != '0) && bus.mem_wreg &&
                              (bus.mem_destR == w_addr[gi]) ? bus.mem_result : w_rf[gi];
         end else begin : g_nofwd
            assign w_op[gi] = w_rf[gi];
         end
      end
   endgenerate

   assign bus.reg_content = r_regs[bus.which_reg];
   assign bus.id_ready    = ~w_stall;
   assign bus.id_valid    = r_valid & ~w_stall;
   assign bus.id_inst     = r_inst;
   assign bus.id_pc4      = r_pc4;
   assign bus.id_inA      = w_op[0];
   assign bus.id_inB      = w_op[1];
   assign bus.id_imm      = w_zext ? {{(DATA_W-16){1'b0}}, r_inst[15:0]}
                                   : {{(DATA_W-16){r_inst[15]}}, r_inst[15:0]};
   assign bus.rs          = w_rs;
   assign bus.rt          = w_rt;
   assign bus.rd          = w_rd;
   assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: a forwarding/16-bit-counter instance and a non-forwarding/
// 2-bit-counter instance share stimulus; expectations go through a scoreboard queue.
module tb_id_stage_hz;
   localparam int DW = 32;
   localparam int AW = 5;

   localparam int S_VALID_A = 0,  S_READY_A = 1,  S_INST_A = 2,  S_PC4_A = 3;
   localparam int S_INA_A   = 4,  S_INB_A   = 5,  S_IMM_A  = 6,  S_CNT_A = 7;
   localparam int S_REG_A   = 8,  S_INA_B   = 9,  S_CNT_B  = 10, S_VALID_B = 11;
   localparam int S_RS_A    = 12, S_RT_A    = 13, S_RD_A   = 14;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   id_stage_hz_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(16)) bus_a ();
   id_stage_hz_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(2))  bus_b ();

   assign bus_b.if_valid   = bus_a.if_valid;
   assign bus_b.if_inst    = bus_a.if_inst;
   assign bus_b.if_pc4     = bus_a.if_pc4;
   assign bus_b.flush      = bus_a.flush;
   assign bus_b.ex_m2reg   = bus_a.ex_m2reg;
   assign bus_b.ex_wreg    = bus_a.ex_wreg;
   assign bus_b.ex_destR   = bus_a.ex_destR;
   assign bus_b.mem_wreg   = bus_a.mem_wreg;
   assign bus_b.mem_destR  = bus_a.mem_destR;
   assign bus_b.mem_result = bus_a.mem_result;
   assign bus_b.wb_wreg    = bus_a.wb_wreg;
   assign bus_b.wb_destR   = bus_a.wb_destR;
   assign bus_b.wb_dest    = bus_a.wb_dest;
   assign bus_b.which_reg  = bus_a.which_reg;

   id_stage_hz #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_EN(1), .CNT_W(16)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   id_stage_hz #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_EN(0), .CNT_W(2)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   function automatic logic [31:0] mk_r(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                        input logic [4:0] rd_f);
      return {6'h00, rs_f, rt_f, rd_f, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs_f,
                                        input logic [4:0] rt_f, input logic [15:0] imm);
      return {op, rs_f, rt_f, imm};
   endfunction

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_VALID_A: return {31'd0, bus_a.id_valid};
         S_READY_A: return {31'd0, bus_a.id_ready};
         S_INST_A:  return bus_a.id_inst;
         S_PC4_A:   return bus_a.id_pc4;
         S_INA_A:   return bus_a.id_inA;
         S_INB_A:   return bus_a.id_inB;
         S_IMM_A:   return bus_a.id_imm;
         S_CNT_A:   return {16'd0, bus_a.stall_cnt};
         S_REG_A:   return bus_a.reg_content;
         S_INA_B:   return bus_b.id_inA;
         S_CNT_B:   return {30'd0, bus_b.stall_cnt};
         S_VALID_B: return {31'd0, bus_b.id_valid};
         S_RS_A:    return {27'd0, bus_a.rs};
         S_RT_A:    return {27'd0, bus_a.rt};
         S_RD_A:    return {27'd0, bus_a.rd};
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, obs);
      end
   endtask

   task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_side();
      bus_a.flush    = 1'b0;
      bus_a.ex_m2reg = 1'b0;
      bus_a.ex_wreg  = 1'b0;
      bus_a.ex_destR = '0;
      bus_a.mem_wreg = 1'b0;
      bus_a.mem_destR = '0;
      bus_a.mem_result = '0;
      bus_a.wb_wreg  = 1'b0;
      bus_a.wb_destR = '0;
      bus_a.wb_dest  = '0;
   endtask

   task automatic load_in_ex(input logic [4:0] dst);
      bus_a.ex_m2reg = 1'b1;
      bus_a.ex_wreg  = 1'b1;
      bus_a.ex_destR = dst;
   endtask

   initial begin
      logic [31:0] i_add9;
      logic [31:0] i_nop1;
      i_add9 = mk_r(5'd8, 5'd10, 5'd9);
      i_nop1 = mk_r(5'd1, 5'd1, 5'd1);

      bus_a.if_valid  = 1'b0;
      bus_a.if_inst   = '0;
      bus_a.if_pc4    = '0;
      bus_a.which_reg = 5'd5;
      clear_side();

      repeat (2) @(posedge clk);
      #1;
      push_exp("rst_valid", S_VALID_A, 32'd0);
      push_exp("rst_cnt", S_CNT_A, 32'd0);
      push_exp("rst_reg5", S_REG_A, 32'd0);
      drain();
      rst = 1'b1;

      // add r4,r3,r0 in ID while WB writes r3
      bus_a.if_valid = 1'b1;
      bus_a.if_inst  = mk_r(5'd3, 5'd0, 5'd4);
      bus_a.if_pc4   = 32'h4;
      step();
      bus_a.wb_wreg  = 1'b1;
      bus_a.wb_destR = 5'd3;
      bus_a.wb_dest  = 32'h1234;
      push_exp("wt_valid", S_VALID_A, 32'd1);
      push_exp("wt_inst", S_INST_A, mk_r(5'd3, 5'd0, 5'd4));
      push_exp("wt_pc4", S_PC4_A, 32'h4);
      push_exp("wt_rs", S_RS_A, 32'd3);
      push_exp("wt_rt", S_RT_A, 32'd0);
      push_exp("wt_rd", S_RD_A, 32'd4);
      push_exp("wt_inA", S_INA_A, 32'h1234);
      push_exp("wt_inA_nofwd", S_INA_B, 32'h1234);
      push_exp("wt_inB_r0", S_INB_A, 32'd0);
      @(negedge clk);
      drain();

      // rs=2 matched by MEM and WB at once: MEM is newer
      bus_a.if_inst = mk_r(5'd2, 5'd5, 5'd6);
      bus_a.if_pc4  = 32'h8;
      step();
      bus_a.wb_destR   = 5'd2;
      bus_a.wb_dest    = 32'hBBBB;
      bus_a.mem_wreg   = 1'b1;
      bus_a.mem_destR  = 5'd2;
      bus_a.mem_result = 32'hAAAA;
      bus_a.which_reg  = 5'd3;
      push_exp("fwd_inA_mem", S_INA_A, 32'hAAAA);
      push_exp("fwd_inA_nofwd", S_INA_B, 32'hBBBB);
      push_exp("fwd_inB", S_INB_A, 32'd0);
      push_exp("rf_r3", S_REG_A, 32'h1234);
      @(negedge clk);
      drain();

      // ori 0x8000, and a WB write to r0
      bus_a.if_inst = mk_i(6'h0D, 5'd0, 5'd1, 16'h8000);
      bus_a.if_pc4  = 32'hC;
      step();
      clear_side();
      bus_a.wb_wreg  = 1'b1;
      bus_a.wb_destR = 5'd0;
      bus_a.wb_dest  = 32'hFFFF;
      push_exp("ori_imm", S_IMM_A, 32'h0000_8000);
      push_exp("ori_inA_r0", S_INA_A, 32'd0);
      @(negedge clk);
      drain();

      // addi 0x8000 reading r2 from the regfile
      bus_a.if_inst = mk_i(6'h08, 5'd2, 5'd7, 16'h8000);
      bus_a.if_pc4  = 32'h10;
      step();
      bus_a.wb_destR  = 5'd5;
      bus_a.wb_dest   = 32'h55;
      bus_a.which_reg = 5'd0;
      push_exp("addi_imm", S_IMM_A, 32'hFFFF_8000);
      push_exp("r0_after_wr", S_REG_A, 32'd0);
      push_exp("addi_inA", S_INA_A, 32'hBBBB);
      push_exp("addi_inA_nofwd", S_INA_B, 32'hBBBB);
      @(negedge clk);
      drain();

      // load-use on rs: one-cycle stall
      bus_a.if_inst = i_add9;
      bus_a.if_pc4  = 32'h14;
      step();
      clear_side();
      load_in_ex(5'd8);
      bus_a.if_inst   = i_nop1;
      bus_a.if_pc4    = 32'h18;
      bus_a.which_reg = 5'd5;
      push_exp("lu_ready", S_READY_A, 32'd0);
      push_exp("lu_valid", S_VALID_A, 32'd0);
      push_exp("lu_valid_b", S_VALID_B, 32'd0);
      push_exp("lu_inst", S_INST_A, i_add9);
      push_exp("lu_cnt0", S_CNT_A, 32'd0);
      push_exp("rf_r5", S_REG_A, 32'h55);
      @(negedge clk);
      drain();
      step();
      clear_side();
      push_exp("lu_hold_inst", S_INST_A, i_add9);
      push_exp("lu_hold_pc4", S_PC4_A, 32'h14);
      push_exp("lu_issue_valid", S_VALID_A, 32'd1);
      push_exp("lu_issue_ready", S_READY_A, 32'd1);
      push_exp("lu_cnt1", S_CNT_A, 32'd1);
      push_exp("lu_cnt1_b", S_CNT_B, 32'd1);
      @(negedge clk);
      drain();
      step();
      push_exp("lu_next_inst", S_INST_A, i_nop1);
      push_exp("lu_next_valid", S_VALID_A, 32'd1);
      drain();

      // beq uses rt; addi's rt is a destination; ex_destR=0 never stalls
      bus_a.if_inst = mk_i(6'h04, 5'd1, 5'd8, 16'h0003);
      step();
      load_in_ex(5'd8);
      #1;
      push_exp("beq_rt_stall", S_READY_A, 32'd0);
      drain();
      load_in_ex(5'd0);
      #1;
      push_exp("dest0_nostall", S_READY_A, 32'd1);
      drain();
      clear_side();
      bus_a.if_inst = mk_i(6'h08, 5'd1, 5'd8, 16'h0001);
      step();
      load_in_ex(5'd8);
      #1;
      push_exp("addi_rt_nostall", S_READY_A, 32'd1);
      drain();
      clear_side();

      // flush and stall together
      bus_a.if_inst = i_add9;
      step();
      load_in_ex(5'd8);
      bus_a.flush = 1'b1;
      #1;
      push_exp("fl_stall_ready", S_READY_A, 32'd0);
      drain();
      step();
      bus_a.flush = 1'b0;
      push_exp("fl_valid", S_VALID_A, 32'd0);
      push_exp("fl_inst", S_INST_A, 32'd0);
      push_exp("fl_cnt", S_CNT_A, 32'd2);
      push_exp("fl_cnt_b", S_CNT_B, 32'd2);
      @(negedge clk);
      drain();
      clear_side();

      // five more stall cycles: the 2-bit counter saturates at 3
      step();
      load_in_ex(5'd8);
      repeat (5) step();
      push_exp("sat_cnt_a", S_CNT_A, 32'd7);
      push_exp("sat_cnt_b", S_CNT_B, 32'd3);
      push_exp("sat_hold_inst", S_INST_A, i_add9);
      @(negedge clk);
      drain();
      clear_side();

      // asynchronous reset mid-cycle with a valid instruction in ID
      step();
      push_exp("pre_rst_valid", S_VALID_A, 32'd1);
      drain();
      #3;
      rst = 1'b0;
      #1;
      push_exp("arst_valid", S_VALID_A, 32'd0);
      push_exp("arst_valid_b", S_VALID_B, 32'd0);
      push_exp("arst_cnt", S_CNT_A, 32'd0);
      push_exp("arst_cnt_b", S_CNT_B, 32'd0);
      push_exp("arst_reg5", S_REG_A, 32'd0);
      push_exp("arst_inst", S_INST_A, 32'd0);
      drain();
      step();
      rst = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
